// File: rtl/signal_types_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// signal_types_pkg : shared DAC sample and bank-scheduler types (rev 1.0)
// ------------------------------------------------------------------
package signal_types_pkg;

   localparam int unsigned DAC_CH_WIDTH = 16;

   typedef struct packed {
      logic [DAC_CH_WIDTH-1:0] ch1;
      logic [DAC_CH_WIDTH-1:0] ch0;
   } dac_sample_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      PLAY     = 2'd1,
      PEND     = 2'd2,
      STOPPING = 2'd3
   } dac_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dac_bank_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_bank_scheduler_if : CPU/config bus into the bank scheduler (rev 1.0)
// ------------------------------------------------------------------
interface dac_bank_scheduler_if
   import signal_types_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 11
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] addr;
   dac_sample_t           data;
   logic [ADDR_WIDTH-1:0] len;
   logic                  commit;
   logic                  stop;
   logic                  busy;
   logic                  err;

   modport master (
      output wr_en, addr, data, len, commit, stop,
      input  busy, err
   );

   modport slave (
      input  wr_en, addr, data, len, commit, stop,
      output busy, err
   );
endinterface
`default_nettype wire

// File: rtl/dac_bank_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// dac_bank_scheduler : ping-pong waveform bank swap at loop wrap (rev 1.0)
// ------------------------------------------------------------------
module dac_bank_scheduler
   import signal_types_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 11
)(
   input  logic                  clk,
   input  logic                  rst_n,
   dac_bank_scheduler_if.slave   cfg,
   output logic                  bank_o,
   output logic                  play_en_o,
   output logic [ADDR_WIDTH-1:0] play_len_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  rd_en_i,
   output dac_sample_t           rd_data_o,
   output logic [ADDR_WIDTH:0]   mem_raddr_o,
   output logic                  mem_re_o,
   input  dac_sample_t           mem_rdata_i,
   output logic [ADDR_WIDTH:0]   mem_waddr_o,
   output logic                  mem_we_o,
   output dac_sample_t           mem_wdata_o
);

   dac_sched_state_t      state_q, state_d;
   logic                  bank_q, bank_d;
   logic                  play_en_q, play_en_d;
   logic [ADDR_WIDTH-1:0] play_len_q, play_len_d;
   logic [ADDR_WIDTH-1:0] pend_len_q, pend_len_d;
   logic                  err_q, err_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
   dac_sample_t           wdata_q, wdata_d;

   logic w_wrap;
   logic w_commit_ok;
   logic w_commit_rej;
   logic w_wr_rej;

   assign w_wrap      = rd_en_i && (rd_addr_i == play_len_q - ADDR_WIDTH'(1));
   // Stop always wins over a simultaneous commit.
   assign w_commit_ok = cfg.commit && !cfg.stop && (cfg.len != '0);

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      play_en_d    = play_en_q;
      play_len_d   = play_len_q;
      pend_len_d   = pend_len_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      w_commit_rej = 1'b0;
      w_wr_rej     = 1'b0;

      // The shadow bank is frozen between commit and swap.
      if (cfg.wr_en) begin
         if (state_q == PEND) begin
            w_wr_rej = 1'b1;
         end else begin
            we_d    = 1'b1;
            waddr_d = {~bank_q, cfg.addr};
            wdata_d = cfg.data;
         end
      end

      case (state_q)
         EMPTY: begin
            w_commit_rej = cfg.commit && !w_commit_ok;
            if (w_commit_ok) begin
               state_d    = PLAY;
               bank_d     = ~bank_q;
               play_len_d = cfg.len;
               play_en_d  = 1'b1;
            end
         end
         PLAY: begin
            w_commit_rej = cfg.commit && !w_commit_ok;
            if (cfg.stop) begin
               state_d = STOPPING;
            end else if (w_commit_ok) begin
               pend_len_d = cfg.len;
               state_d    = PEND;
            end
         end
         PEND: begin
            w_commit_rej = cfg.commit;
            if (cfg.stop) begin
               state_d = STOPPING;
            end else if (w_wrap) begin
               bank_d     = ~bank_q;
               play_len_d = pend_len_q;
               state_d    = PLAY;
            end
         end
         STOPPING: begin
            w_commit_rej = cfg.commit;
            if (w_wrap) begin
               play_en_d = 1'b0;
               state_d   = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      err_d = w_commit_rej || w_wr_rej;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         bank_q     <= 1'b0;
         play_en_q  <= 1'b0;
         play_len_q <= '0;
         pend_len_q <= '0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         play_en_q  <= play_en_d;
         play_len_q <= play_len_d;
         pend_len_q <= pend_len_d;
         err_q      <= err_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign cfg.busy    = (state_q == PEND) || (state_q == STOPPING);
   assign cfg.err     = err_q;
   assign bank_o      = bank_q;
   assign play_en_o   = play_en_q;
   assign play_len_o  = play_len_q;
   assign mem_raddr_o = {bank_q, rd_addr_i};
   assign mem_re_o    = rd_en_i;
   assign rd_data_o   = mem_rdata_i;
   assign mem_waddr_o = waddr_q;
   assign mem_we_o    = we_q;
   assign mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_bank_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dac_bank_scheduler : vector-table bench with a behavioural sample RAM (rev 1.0)
// ------------------------------------------------------------------
module tb_dac_bank_scheduler;
   import signal_types_pkg::*;

   localparam int AW = 11;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      dac_sample_t   wdat;
      logic [AW-1:0] len;
      logic          commit;
      logic          stop;
      logic          rd_en;
      logic [AW-1:0] rd_addr;
      dac_sample_t   rdat;
      logic          bank;
      logic          en;
      logic [AW-1:0] plen;
      logic          busy;
      logic          err;
      logic          we;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          bank_o, play_en_o, mem_re_o, mem_we_o;
   logic [AW-1:0] play_len_o, rd_addr;
   logic          rd_en;
   dac_sample_t   rd_data_o, mem_rdata_i, mem_wdata_o;
   logic [AW:0]   mem_raddr_o, mem_waddr_o;
   dac_sample_t   ram [0:(1<<(AW+1))-1];

   int   n_chk  = 0;
   int   n_fail = 0;
   logic exp_bank;
   vec_t tbl[$];

   dac_bank_scheduler_if #(.ADDR_WIDTH(AW)) cfg_if ();

   dac_bank_scheduler #(.ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg         (cfg_if),
      .bank_o      (bank_o),
      .play_en_o   (play_en_o),
      .play_len_o  (play_len_o),
      .rd_addr_i   (rd_addr),
      .rd_en_i     (rd_en),
      .rd_data_o   (rd_data_o),
      .mem_raddr_o (mem_raddr_o),
      .mem_re_o    (mem_re_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_waddr_o (mem_waddr_o),
      .mem_we_o    (mem_we_o),
      .mem_wdata_o (mem_wdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mem_we_o) ram[mem_waddr_o] <= mem_wdata_o;
   assign mem_rdata_i = ram[mem_raddr_o];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t v(input int wr, input int addr, input int wd1, input int wd0,
                              input int len, input int commit, input int stop,
                              input int rden, input int rdaddr, input int r1, input int r0,
                              input int bank, input int en, input int plen,
                              input int busy, input int err, input int we);
      vec_t t;
      t.wr = wr[0]; t.addr = AW'(addr); t.wdat = {16'(wd1), 16'(wd0)};
      t.len = AW'(len); t.commit = commit[0]; t.stop = stop[0];
      t.rd_en = rden[0]; t.rd_addr = AW'(rdaddr); t.rdat = {16'(r1), 16'(r0)};
      t.bank = bank[0]; t.en = en[0]; t.plen = AW'(plen);
      t.busy = busy[0]; t.err = err[0]; t.we = we[0];
      return t;
   endfunction

   task automatic idle_inputs();
      cfg_if.wr_en = 1'b0; cfg_if.addr = '0; cfg_if.data = '0; cfg_if.len = '0;
      cfg_if.commit = 1'b0; cfg_if.stop = 1'b0; rd_en = 1'b0; rd_addr = '0;
   endtask

   // Called at posedge+1: drive, check the read path, then check the registered state after the edge.
   task automatic apply(input vec_t t);
      cfg_if.wr_en = t.wr; cfg_if.addr = t.addr; cfg_if.data = t.wdat; cfg_if.len = t.len;
      cfg_if.commit = t.commit; cfg_if.stop = t.stop; rd_en = t.rd_en; rd_addr = t.rd_addr;
      #1;
      if (t.rd_en) begin
         chk("mem_raddr", 64'(mem_raddr_o), 64'({exp_bank, t.rd_addr}));
         chk("mem_re",    64'(mem_re_o),    64'd1);
         chk("rd_data",   64'(rd_data_o),   64'(t.rdat));
      end
      @(posedge clk); #1;
      chk("bank",     64'(bank_o),      64'(t.bank));
      chk("play_en",  64'(play_en_o),   64'(t.en));
      chk("play_len", 64'(play_len_o),  64'(t.plen));
      chk("busy",     64'(cfg_if.busy), 64'(t.busy));
      chk("err",      64'(cfg_if.err),  64'(t.err));
      chk("mem_we",   64'(mem_we_o),    64'(t.we));
      if (t.we) begin
         chk("mem_waddr", 64'(mem_waddr_o), 64'({~exp_bank, t.addr}));
         chk("mem_wdata", 64'(mem_wdata_o), 64'(t.wdat));
      end
      exp_bank = t.bank;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " bank"},     64'(bank_o),      64'd0);
      chk({tag, " play_en"},  64'(play_en_o),   64'd0);
      chk({tag, " play_len"}, 64'(play_len_o),  64'd0);
      chk({tag, " busy"},     64'(cfg_if.busy), 64'd0);
      chk({tag, " err"},      64'(cfg_if.err),  64'd0);
      chk({tag, " mem_we"},   64'(mem_we_o),    64'd0);
      chk({tag, " waddr"},    64'(mem_waddr_o), 64'd0);
      chk({tag, " wdata"},    64'(mem_wdata_o), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < (1 << (AW + 1)); i++) ram[i] = '0;
      idle_inputs();
      exp_bank = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      //              wr a  wd1  wd0 len c s  re ra  r1   r0  bk en pl by er we
      // cold start: fill bank 1, commit len 4, loop it
      tbl.push_back(v(1, 0, 100,  50, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 200, 150, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 2, 300, 250, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 3, 400, 350, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0,   0,   0, 4, 1, 0, 0, 0,    0,   0, 1, 1, 4, 0, 0, 0));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 0,  100,  50, 1, 1, 4, 0, 0, 0));
      // fill bank 0 while bank 1 plays
      tbl.push_back(v(1, 0,1000,  10, 0, 0, 0, 1, 1,  200, 150, 1, 1, 4, 0, 0, 1));
      tbl.push_back(v(1, 1,1001,  11, 0, 0, 0, 1, 2,  300, 250, 1, 1, 4, 0, 0, 1));
      tbl.push_back(v(1, 2,1002,  12, 0, 0, 0, 1, 3,  400, 350, 1, 1, 4, 0, 0, 1));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 0,  100,  50, 1, 1, 4, 0, 0, 0));
      // commit len 3 at rd_addr 1, then rejected write and rejected commit in PEND
      tbl.push_back(v(0, 0,   0,   0, 3, 1, 0, 1, 1,  200, 150, 1, 1, 4, 1, 0, 0));
      tbl.push_back(v(1, 7,   9,   9, 0, 0, 0, 1, 2,  300, 250, 1, 1, 4, 1, 1, 0));
      tbl.push_back(v(0, 0,   0,   0, 2, 1, 0, 0, 0,    0,   0, 1, 1, 4, 1, 1, 0));
      // swap exactly on the rd_addr 3 edge, then bank 0 with len 3
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 3,  400, 350, 0, 1, 3, 0, 0, 0));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 0, 1000,  10, 0, 1, 3, 0, 0, 0));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 1, 1001,  11, 0, 1, 3, 0, 0, 0));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 2, 1002,  12, 0, 1, 3, 0, 0, 0));
      tbl.push_back(v(0, 0,   0,   0, 0, 0, 0, 1, 0, 1000,  10, 0, 1, 3, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i]);

      // Reset in the middle of PEND clears every output without a clock edge.
      apply(v(1, 5, 77, 66, 2, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 1));
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_bank = 1'b0;

      // Zero-length commit rejected in EMPTY; err is a single-cycle pulse.
      apply(v(0, 0, 0, 0, 0, 1, 0, 0, 0,   0,   0, 0, 0, 0, 0, 1, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0));
      // Stop at rd_addr 1 with len 4: play_en falls after the rd_addr 3 edge, no flip.
      apply(v(0, 0, 0, 0, 4, 1, 0, 0, 0,   0,   0, 1, 1, 4, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 100,  50, 1, 1, 4, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 1, 1, 1, 200, 150, 1, 1, 4, 1, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 2, 300, 250, 1, 1, 4, 1, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 400, 350, 1, 0, 4, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0,   0,   0, 1, 0, 4, 0, 0, 0));
      // Stop and commit together in PLAY: stop wins, commit flagged.
      apply(v(0, 0, 0, 0, 4, 1, 0, 0, 0,   0,   0, 0, 1, 4, 0, 0, 0));
      apply(v(0, 0, 0, 0, 2, 1, 1, 0, 0,   0,   0, 0, 1, 4, 1, 1, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 3,   0,   0, 0, 0, 4, 0, 0, 0));
      // len 1: every read wraps; commit on a wrap defers the swap to the next wrap.
      apply(v(0, 0, 0, 0, 1, 1, 0, 0, 0,   0,   0, 1, 1, 1, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 100,  50, 1, 1, 1, 0, 0, 0));
      apply(v(0, 0, 0, 0, 2, 1, 0, 1, 0, 100,  50, 1, 1, 1, 1, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 100,  50, 0, 1, 2, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 0,1000,  10, 0, 1, 2, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1,1001,  11, 0, 1, 2, 0, 0, 0));
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
